pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//   Sequences the board PLL and the system resets it feeds. Pulses the PLL reset, waits for lock, qualifies lock stability,
//   then releases N_RST downstream resets in order (bit 0 first). Runs on the 50 MHz reference clock, ahead of the PLL.
//   Re-sequences on lock loss or soft request; retries on lock timeout and flags a fault after MAX_RETRIES.
// PARAMETERS
//   PLL_RST_CYCLES      16     pll_rst high time per attempt, refclk cycles (>=1)
//   LOCK_STABLE_CYCLES  1024   consecutive synced-lock cycles required before release (>=1)
//   LOCK_TIMEOUT_CYCLES 50000  max cycles from WAIT_LOCK entry to RELEASE entry (1 ms @ 50 MHz)
//   STAGE_GAP_CYCLES    64     cycles between successive rst_out releases (>=1)
//   N_RST               3      number of sequenced reset outputs (1..8)
//   MAX_RETRIES         4      timeouts tolerated before FAULT (1..15)
// PORTS
//   refclk       in   1      reference clock; only clock in the block
//   rst          in   1      synchronous, active-high reset
//   pll_locked   in   1      PLL lock, asynchronous to refclk
//   soft_req     in   1      one-cycle request to restart the whole sequence
//   pll_rst      out  1      PLL reset, active-high
//   rst_out      out  N_RST  sequenced resets, active-high; bit i released after bit i-1
//   ready        out  1      high in RUN only
//   fault        out  1      high in FAULT only
//   retry_cnt    out  4      timeouts in the current bring-up; saturates at MAX_RETRIES
// BEHAVIOUR
//   Reset (rst=1 at an edge): state=RESET_PLL, pll_rst=1, rst_out=all 1, ready=0, fault=0, retry_cnt=0, counters=0.
//   rst has priority over every other input.
//   lock_s = pll_locked through a 2-flop synchronizer. lock_s follows pll_locked 2 edges later; sync flops reset to 0.
//   All outputs are registered and reflect the current state.
//   States and transitions:
//     RESET_PLL: pll_rst=1, rst_out=all 1. After PLL_RST_CYCLES cycles -> WAIT_LOCK. Timeout counter cleared.
//     WAIT_LOCK: pll_rst=0. Timeout counter runs. lock_s=1 -> STABLE, stability counter=0.
//     STABLE:    pll_rst=0. Timeout counter keeps running.
//                lock_s=0 -> WAIT_LOCK. Stability counter cleared; no retry charged.
//                LOCK_STABLE_CYCLES consecutive lock_s=1 -> RELEASE.
//     Timeout:   timeout counter reaches LOCK_TIMEOUT_CYCLES in WAIT_LOCK or STABLE -> retry_cnt+1.
//                If new retry_cnt==MAX_RETRIES -> FAULT, else -> RESET_PLL.
//     RELEASE:   stage counter runs from 0. rst_out[i] clears at cycle STAGE_GAP_CYCLES*(i+1) after entry.
//                A cleared bit never re-sets while in RELEASE.
//                The cycle rst_out[N_RST-1] clears -> RUN.
//     RUN:       rst_out=0, ready=1, retry_cnt cleared to 0 on entry.
//     FAULT:     pll_rst=1, rst_out=all 1, fault=1. Leaves only via rst or soft_req.
//   Lock loss: lock_s=0 in RELEASE or RUN -> next state RESET_PLL.
//     rst_out=all 1 and ready=0 on the following edge. retry_cnt is not charged.
//   soft_req=1 in any state -> RESET_PLL, retry_cnt=0. soft_req wins over a simultaneous lock loss or timeout.
//   Timeout and lock_s rising in the same WAIT_LOCK cycle: timeout wins.
//   Counters are sized $clog2(max+1) and never wrap; each is cleared on every state entry that uses it.
// STRUCTURE
//   pll_seq_pkg: state enum {RESET_PLL, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT}, RETRY_W=4.
//   Sub-module sync_2ff: generic 1-bit 2-flop synchronizer with reset value parameter; instantiated for pll_locked.
//   Single FSM plus three counters (phase/stability, timeout, stage) in the top module.
// TESTING (params: PLL_RST=4, STABLE=8, TIMEOUT=100, GAP=4, N_RST=3, RETRIES=2)
//   rst released, pll_locked=1 from t=0 -> pll_rst high 4 cycles; rst_out 111->110->100->000 at 4-cycle steps; ready=1.
//   pll_locked never rises -> pll_rst re-pulses after 100 WAIT_LOCK cycles, retry_cnt=1;
//     second timeout -> fault=1, retry_cnt=2, outputs held.
//   pll_locked glitches low for 3 cycles at stability count 5 -> back to WAIT_LOCK;
//     release starts only after 8 fresh cycles; retry_cnt stays 0.
//   Drop pll_locked in RUN -> rst_out=111, ready=0 within 4 edges; full sequence repeats.
//   soft_req in FAULT, and in RELEASE with rst_out=100 -> RESET_PLL; fault=0, retry_cnt=0, rst_out=111.
//   Assert rst mid-RELEASE with soft_req=1 -> reset values next edge; sequence restarts cleanly.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reset sequencer: FSM state encoding and status widths.
// Pure declarations; no logic, no latency.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } seq_state_e;

    localparam int RETRY_W = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Board-side signal bundle of the sequencer: PLL lock/reset, soft request and sequenced resets.
// Wires only; master is the sequencer, slave is the board or bench.
interface pll_reset_sequencer_if #(
    parameter int N_RST = 3
);
    import pll_seq_pkg::*;

    logic               pll_locked;
    logic               soft_req;
    logic               pll_rst;
    logic [N_RST-1:0]   rst_out;
    logic               ready;
    logic               fault;
    logic [RETRY_W-1:0] retry_cnt;

    modport master (
        input  pll_locked, soft_req,
        output pll_rst, rst_out, ready, fault, retry_cnt
    );

    modport slave (
        output pll_locked, soft_req,
        input  pll_rst, rst_out, ready, fault, retry_cnt
    );

endinterface

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with a configurable reset value.
// Latency: 2 clock edges; no backpressure.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses PLL reset, qualifies lock, then releases rst_out bit 0 first; retries on timeout, faults after MAX_RETRIES.
// Outputs registered, one edge after the deciding input; no backpressure (soft_req is a one-cycle pulse).
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int STAGE_GAP_CYCLES    = 64,
    parameter int N_RST               = 3,
    parameter int MAX_RETRIES         = 4
) (
    input  logic                 refclk,
    input  logic                 rst,
    pll_reset_sequencer_if.master sq
);

    localparam int PH_W = $clog2(max2(PLL_RST_CYCLES, LOCK_STABLE_CYCLES) + 1);
    localparam int TO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int ST_W = $clog2(STAGE_GAP_CYCLES * N_RST + 1);

    seq_state_e         state_q, state_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [TO_W-1:0]    to_q, to_d, to_inc;
    logic [ST_W-1:0]    stage_q, stage_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic               pll_rst_q, pll_rst_d;
    logic [N_RST-1:0]   rst_out_q, rst_out_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;
    logic               lock_s;
    logic               timeout_hit;

    sync_2ff #(.RESET_VAL(1'b0)) u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (sq.pll_locked),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        to_d        = to_q;
        stage_d     = stage_q;
        retry_d     = retry_q;
        to_inc      = to_q + TO_W'(1);
        retry_inc   = retry_q + RETRY_W'(1);
        timeout_hit = (to_inc == TO_W'(LOCK_TIMEOUT_CYCLES));

        case (state_q)
            RESET_PLL: begin
                if (ph_q == PH_W'(PLL_RST_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                    to_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            WAIT_LOCK, STABLE: begin
                to_d = to_inc;
                // Timeout is judged first so a late lock edge cannot rescue an expired attempt.
                if (timeout_hit) begin
                    retry_d = retry_inc;
                    ph_d    = '0;
                    state_d = (retry_inc == RETRY_W'(MAX_RETRIES)) ? FAULT : RESET_PLL;
                end else if (state_q == WAIT_LOCK) begin
                    if (lock_s) begin
                        state_d = STABLE;
                        ph_d    = '0;
                    end
                end else if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    ph_d    = '0;
                end else if (ph_q == PH_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = RELEASE;
                    stage_d = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    state_d = RESET_PLL;
                    ph_d    = '0;
                end else begin
                    stage_d = stage_q + ST_W'(1);
                    if (stage_d == ST_W'(STAGE_GAP_CYCLES * N_RST)) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = RESET_PLL;
                    ph_d    = '0;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = RESET_PLL;
                ph_d    = '0;
            end
        endcase

        if (sq.soft_req) begin
            state_d = RESET_PLL;
            ph_d    = '0;
            retry_d = '0;
        end

        pll_rst_d = (state_d == RESET_PLL) || (state_d == FAULT);
        ready_d   = (state_d == RUN);
        fault_d   = (state_d == FAULT);
        rst_out_d = '1;
        // Release mask comes straight from the monotonic stage count, so a cleared bit stays cleared.
        for (int i = 0; i < N_RST; i++) begin
            rst_out_d[i] = !((state_d == RUN) ||
                             ((state_d == RELEASE) &&
                              (stage_d >= ST_W'(STAGE_GAP_CYCLES * (i + 1)))));
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= RESET_PLL;
            ph_q      <= '0;
            to_q      <= '0;
            stage_q   <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            to_q      <= to_d;
            stage_q   <= stage_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign sq.pll_rst   = pll_rst_q;
    assign sq.rst_out   = rst_out_q;
    assign sq.ready     = ready_q;
    assign sq.fault     = fault_q;
    assign sq.retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench: stimulus pushes hand-computed output snapshots with their cycle numbers into a queue;
// a negedge monitor pops one entry per observed output change and compares value and cycle.
module tb_pll_reset_sequencer;

    logic refclk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [9:0] snap;
        int         at;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    pll_reset_sequencer_if #(.N_RST(3)) bus ();

    pll_reset_sequencer #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (100),
        .STAGE_GAP_CYCLES    (4),
        .N_RST               (3),
        .MAX_RETRIES         (2)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .sq     (bus.master)
    );

    always #10 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    function automatic logic [9:0] mk(input logic p, input logic [2:0] r, input logic rdy,
                                      input logic f, input logic [3:0] rc);
        return {p, r, rdy, f, rc};
    endfunction

    task automatic push(input logic [9:0] s, input int at, input string name);
        exp_t e;
        e.snap = s;
        e.at   = at;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Steady lock from RESET_PLL entry at edge r: WAIT_LOCK r+4, RELEASE r+13, bit steps every 4 edges.
    task automatic push_bringup(input int r, input logic [3:0] rc, input bit to_run);
        push(mk(1'b0, 3'b111, 1'b0, 1'b0, rc), r + 4,  "pll_rst_low");
        push(mk(1'b0, 3'b110, 1'b0, 1'b0, rc), r + 17, "rel_bit0");
        push(mk(1'b0, 3'b100, 1'b0, 1'b0, rc), r + 21, "rel_bit1");
        if (to_run)
            push(mk(1'b0, 3'b000, 1'b1, 1'b0, 4'd0), r + 25, "run");
    endtask

    task automatic wait_neg(input int n);
        do @(negedge refclk); while (cyc < n);
    endtask

    logic [9:0] prev;
    bit         first = 1'b1;

    always @(negedge refclk) begin
        logic [9:0] got;
        exp_t       e;
        if (cyc >= 2) begin
            got = {bus.pll_rst, bus.rst_out, bus.ready, bus.fault, bus.retry_cnt};
            if (first || got !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %b at cycle %0d, want no change", got, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e.snap || cyc != e.at) begin
                        errors++;
                        $display("FAIL %s: got %b at cycle %0d, want %b at cycle %0d",
                                 e.name, got, cyc, e.snap, e.at);
                    end
                end
            end
            prev  = got;
            first = 1'b0;
        end
    end

    initial begin
        exp_t e;
        rst            = 1'b1;
        bus.pll_locked = 1'b1;
        bus.soft_req   = 1'b0;

        // Clean bring-up straight out of reset.
        push(mk(1'b1, 3'b111, 1'b0, 1'b0, 4'd0), 2, "reset_state");
        push_bringup(2, 4'd0, 1'b1);
        wait_neg(2);
        rst = 1'b0;

        // Lock loss in RUN, then immediate relock.
        wait_neg(30);
        push(mk(1'b1, 3'b111, 1'b0, 1'b0, 4'd0), 33, "lockloss_run");
        bus.pll_locked = 1'b0;
        wait_neg(33);
        bus.pll_locked = 1'b1;
        push_bringup(33, 4'd0, 1'b1);

        // Lock never returns: two timeouts end in FAULT.
        wait_neg(60);
        bus.pll_locked = 1'b0;
        push(mk(1'b1, 3'b111, 1'b0, 1'b0, 4'd0), 63,  "lockloss_run2");
        push(mk(1'b0, 3'b111, 1'b0, 1'b0, 4'd0), 67,  "wait_lock_a");
        push(mk(1'b1, 3'b111, 1'b0, 1'b0, 4'd1), 167, "timeout1");
        push(mk(1'b0, 3'b111, 1'b0, 1'b0, 4'd1), 171, "wait_lock_b");
        push(mk(1'b1, 3'b111, 1'b0, 1'b1, 4'd2), 271, "fault");

        // soft_req leaves FAULT; a second soft_req lands in RELEASE with rst_out=100.
        wait_neg(280);
        bus.pll_locked = 1'b1;
        wait_neg(290);
        push(mk(1'b1, 3'b111, 1'b0, 1'b0, 4'd0), 291, "soft_from_fault");
        push(mk(1'b0, 3'b111, 1'b0, 1'b0, 4'd0), 295, "pll_rst_low_s");
        push(mk(1'b0, 3'b110, 1'b0, 1'b0, 4'd0), 308, "rel_bit0_s");
        push(mk(1'b0, 3'b100, 1'b0, 1'b0, 4'd0), 312, "rel_bit1_s");
        push(mk(1'b1, 3'b111, 1'b0, 1'b0, 4'd0), 314, "soft_in_release");
        push_bringup(314, 4'd0, 1'b1);
        bus.soft_req = 1'b1;
        wait_neg(291);
        bus.soft_req = 1'b0;
        wait_neg(313);
        bus.soft_req = 1'b1;
        wait_neg(314);
        bus.soft_req = 1'b0;

        // Three-cycle lock glitch at stability count 5 restarts qualification.
        wait_neg(345);
        bus.pll_locked = 1'b0;
        push(mk(1'b1, 3'b111, 1'b0, 1'b0, 4'd0), 348, "lockloss_run3");
        wait_neg(348);
        bus.pll_locked = 1'b1;
        push(mk(1'b0, 3'b111, 1'b0, 1'b0, 4'd0), 352, "pll_rst_low_g");
        push(mk(1'b0, 3'b110, 1'b0, 1'b0, 4'd0), 374, "rel_bit0_g");
        push(mk(1'b0, 3'b100, 1'b0, 1'b0, 4'd0), 378, "rel_bit1_g");
        push(mk(1'b0, 3'b000, 1'b1, 1'b0, 4'd0), 382, "run_g");
        wait_neg(356);
        bus.pll_locked = 1'b0;
        wait_neg(359);
        bus.pll_locked = 1'b1;

        // rst together with soft_req in RELEASE: reset wins, sync flops restart from 0.
        wait_neg(385);
        bus.pll_locked = 1'b0;
        push(mk(1'b1, 3'b111, 1'b0, 1'b0, 4'd0), 388, "lockloss_run4");
        wait_neg(388);
        bus.pll_locked = 1'b1;
        push(mk(1'b0, 3'b111, 1'b0, 1'b0, 4'd0), 392, "pll_rst_low_r");
        push(mk(1'b0, 3'b110, 1'b0, 1'b0, 4'd0), 405, "rel_bit0_r");
        push(mk(1'b1, 3'b111, 1'b0, 1'b0, 4'd0), 407, "rst_in_release");
        push_bringup(407, 4'd0, 1'b1);
        wait_neg(406);
        rst          = 1'b1;
        bus.soft_req = 1'b1;
        wait_neg(407);
        rst          = 1'b0;
        bus.soft_req = 1'b0;

        // One timeout, then success: retry_cnt shows 1 until RUN clears it.
        wait_neg(440);
        bus.pll_locked = 1'b0;
        push(mk(1'b1, 3'b111, 1'b0, 1'b0, 4'd0), 443, "lockloss_run5");
        push(mk(1'b0, 3'b111, 1'b0, 1'b0, 4'd0), 447, "wait_lock_c");
        push(mk(1'b1, 3'b111, 1'b0, 1'b0, 4'd1), 547, "timeout_c");
        push_bringup(547, 4'd1, 1'b1);
        wait_neg(548);
        bus.pll_locked = 1'b1;

        wait_neg(600);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: got no change by cycle %0d, want %b at cycle %0d", e.name, cyc, e.snap, e.at);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
